// File: rtl/lsu_word_port.sv
// Load/store unit in front of a 32-bit little-endian word RAM port; sub-word stores use read-modify-write.
// Optional: define MISALIGN_TRAP_EN to answer misaligned or reserved-size requests with rsp_err instead of accessing RAM.
`timescale 1ns/1ps
module lsu_word_port #(
   parameter int unsigned              ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]        ADDR_MASK = ADDR_W'(32'h0000_FFFF)
) (
   input  logic              m_clock,
   input  logic              p_reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned HALF_W = 16;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [1:0]          addr_lo_q, addr_lo_d;
   logic [1:0]          size_q, size_d;
   logic                we_q, we_d;
   logic                uns_q, uns_d;
   logic [HALF_W-1:0]   wdata_q, wdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                trap_c;

   // Lane extract plus sign/zero extension; any word-class size passes the word through.
   function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] w, input logic [1:0] sz,
                                                 input logic [1:0] lo, input logic uns);
      logic [7:0]        b;
      logic [HALF_W-1:0] h;
      b = w[{lo, 3'b000} +: 8];
      h = lo[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   return {{24{~uns & b[7]}}, b};
         2'b01:   return {{16{~uns & h[15]}}, h};
         default: return w;
      endcase
   endfunction

   // Replace only the addressed lane(s) of the word read back from RAM.
   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] w, input logic [HALF_W-1:0] d,
                                               input logic [1:0] sz, input logic [1:0] lo);
      logic [DATA_W-1:0] r;
      r = w;
      if (sz == 2'b00) begin
         r[{lo, 3'b000} +: 8] = d[7:0];
      end else if (lo[1]) begin
         r[31:16] = d;
      end else begin
         r[15:0] = d;
      end
      return r;
   endfunction

`ifdef MISALIGN_TRAP_EN
   always_comb begin
      trap_c = 1'b0;
      case (req_size)
         2'b01:   trap_c = req_addr[0];
         2'b10:   trap_c = (req_addr[1:0] != 2'b00);
         2'b11:   trap_c = 1'b1;
         default: trap_c = 1'b0;
      endcase
   end
`else
   assign trap_c = 1'b0;
`endif

   always_ff @(posedge m_clock) begin
      if (!p_reset) begin
         state_q     <= S_IDLE;
         addr_lo_q   <= 2'b00;
         size_q      <= 2'b00;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_lo_q   <= addr_lo_d;
         size_q      <= size_d;
         we_q        <= we_d;
         uns_q       <= uns_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Next-state and register updates; word stores skip the read cycle.
   always_comb begin
      state_d     = state_q;
      addr_lo_d   = addr_lo_q;
      size_d      = size_q;
      we_d        = we_q;
      uns_d       = uns_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_lo_d   = req_addr[1:0];
               size_d      = req_size;
               we_d        = req_we;
               uns_d       = req_unsigned;
               wdata_d     = req_wdata[15:0];
               mem_addr_d  = req_addr & ADDR_MASK & ~ADDR_W'(3);
               mem_wdata_d = req_wdata;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               if (trap_c) begin
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = S_RESP;
               end else if (req_we && req_size[1]) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            if (we_q) begin
               mem_wdata_d = merge(mem_rdata, wdata_q, size_q, addr_lo_q);
               state_d     = S_WR;
            end else begin
               rsp_rdata_d = extract(mem_rdata, size_q, addr_lo_q, uns_q);
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_WR: begin
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake and write strobe are gated by reset so nothing leaks out while it is held.
   assign req_ready = p_reset && (state_q == S_IDLE);
   assign mem_we    = p_reset && (state_q == S_WR);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
